// File: rtl/mul_ctrl_seq_gen_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mul_ctrl_seq_gen_if : handshake and control bus of the multiplier sequencer
//   (STALL is present only when MUL_CTRL_SEQ_STALL_EN is defined)
// Revision: 1.0
// ----------------------------------------------------------------------------
interface mul_ctrl_seq_gen_if #(
  parameter int NB = 4
);
  localparam int SW = $clog2(2 * NB);
  localparam int CW = $clog2(NB) + 1;

  logic             START;
  logic             MODE;
  logic             ABORT;
`ifdef MUL_CTRL_SEQ_STALL_EN
  logic             STALL;
`endif
  logic             BUSY;
  logic             DONE;
  logic [SW-1:0]    PHASE;
  logic [NB*CW-1:0] CTRL_B;
  logic             CARRY_IN;
  logic [SW-1:0]    CTRL_IN_BUF;

`ifdef MUL_CTRL_SEQ_STALL_EN
  modport master (
    output START, MODE, ABORT, STALL,
    input  BUSY, DONE, PHASE, CTRL_B, CARRY_IN, CTRL_IN_BUF
  );
  modport slave (
    input  START, MODE, ABORT, STALL,
    output BUSY, DONE, PHASE, CTRL_B, CARRY_IN, CTRL_IN_BUF
  );
`else
  modport master (
    output START, MODE, ABORT,
    input  BUSY, DONE, PHASE, CTRL_B, CARRY_IN, CTRL_IN_BUF
  );
  modport slave (
    input  START, MODE, ABORT,
    output BUSY, DONE, PHASE, CTRL_B, CARRY_IN, CTRL_IN_BUF
  );
`endif
endinterface
`default_nettype wire

// File: rtl/mul_ctrl_seq_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mul_ctrl_seq_gen : staggered lane-code / carry / buffer-index sequencer for
//   the NB-lane bit-serial multiplier. Optional pause: MUL_CTRL_SEQ_STALL_EN
// Revision: 1.0
// ----------------------------------------------------------------------------
module mul_ctrl_seq_gen #(
  parameter int NB      = 4,
  parameter int BUF_OFS = 2
) (
  input  logic                CLK,
  input  logic                RST,
  mul_ctrl_seq_gen_if.slave   bus
);

  localparam int            SW        = $clog2(2 * NB);
  localparam int            CW        = $clog2(NB) + 1;
  localparam logic [CW-1:0] IDLE_CODE = '1;
  localparam logic [SW-1:0] LAST_PH   = SW'(2 * NB - 1);
  localparam logic [SW-1:0] RST_PHASE = SW'((2 * NB - BUF_OFS) % (2 * NB));

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    phase_q, phase_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [NB*CW-1:0] ctrl_b_q, ctrl_b_d;
  logic             carry_q, carry_d;
  logic [SW-1:0]    buf_q, buf_d;
  logic             stall;

`ifdef MUL_CTRL_SEQ_STALL_EN
  assign stall = bus.STALL;
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    if (bus.ABORT) begin
      state_d = S_IDLE;
      phase_d = RST_PHASE;
    end else begin
      case (state_q)
        S_IDLE: begin
          phase_d = RST_PHASE;
          if (bus.START) begin
            state_d = (BUF_OFS == 0) ? S_RUN : S_PRE;
          end
        end
        S_PRE: begin
          if (!stall) begin
            phase_d = phase_q + 1'b1;
            if (phase_q == LAST_PH) begin
              state_d = S_RUN;
            end
          end
        end
        S_RUN: begin
          if (!stall) begin
            if (phase_q == LAST_PH) begin
              state_d = bus.MODE ? S_RUN : S_IDLE;
              phase_d = bus.MODE ? '0 : RST_PHASE;
            end else begin
              phase_d = phase_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          phase_d = RST_PHASE;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so the registered copies always
  // match the decode of the current state/phase registers.
  always_comb begin
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_RUN) && (phase_d == LAST_PH);
    carry_d  = (state_d == S_RUN) && (phase_d >= SW'(NB));
    buf_d    = (state_d == S_IDLE) ? '0 : (phase_d + SW'(BUF_OFS));
    ctrl_b_d = {NB{IDLE_CODE}};
    if (state_d == S_RUN) begin
      for (int k = 0; k < NB; k++) begin
        if ((phase_d >= SW'(k)) && (phase_d <= SW'(k + NB - 1))) begin
          ctrl_b_d[k*CW +: CW] = CW'(phase_d - SW'(k));
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      phase_q  <= RST_PHASE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ctrl_b_q <= {NB{IDLE_CODE}};
      carry_q  <= 1'b0;
      buf_q    <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ctrl_b_q <= ctrl_b_d;
      carry_q  <= carry_d;
      buf_q    <= buf_d;
    end
  end

  assign bus.BUSY        = busy_q;
  assign bus.DONE        = done_q & ~stall;
  assign bus.PHASE       = phase_q;
  assign bus.CTRL_B      = ctrl_b_q;
  assign bus.CARRY_IN    = carry_q;
  assign bus.CTRL_IN_BUF = buf_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_ctrl_seq_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mul_ctrl_seq_gen : directed self-checking bench, NB=4/BUF_OFS=2 and
//   NB=8/BUF_OFS=3 instances. Revision: 1.0
// ----------------------------------------------------------------------------
module tb_mul_ctrl_seq_gen;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  mul_ctrl_seq_gen_if #(.NB(4)) if4 ();
  mul_ctrl_seq_gen_if #(.NB(8)) if8 ();

  mul_ctrl_seq_gen #(.NB(4), .BUF_OFS(2)) u_dut4 (.CLK(clk), .RST(rst), .bus(if4));
  mul_ctrl_seq_gen #(.NB(8), .BUF_OFS(3)) u_dut8 (.CLK(clk), .RST(rst), .bus(if8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_tests++; if (if4.BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0h want 0", if4.BUSY); end
    n_tests++; if (if4.DONE !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0h want 0", if4.DONE); end
    n_tests++; if (if4.PHASE !== 3'd6) begin n_fail++; $display("FAIL reset_phase: got %0d want 6", if4.PHASE); end
    n_tests++; if (if4.CTRL_B !== 12'hFFF) begin n_fail++; $display("FAIL reset_ctrl: got %0h want fff", if4.CTRL_B); end
    n_tests++; if (if4.CARRY_IN !== 1'b0) begin n_fail++; $display("FAIL reset_carry: got %0h want 0", if4.CARRY_IN); end
    n_tests++; if (if4.CTRL_IN_BUF !== 3'd0) begin n_fail++; $display("FAIL reset_buf: got %0d want 0", if4.CTRL_IN_BUF); end
    n_tests++; if (if8.PHASE !== 4'd13) begin n_fail++; $display("FAIL reset_phase8: got %0d want 13", if8.PHASE); end
  endtask

  task automatic test_single_shot;
    if4.MODE  = 1'b0;
    if4.START = 1'b1;
    tick();
    if4.START = 1'b0;
    n_tests++; if (if4.BUSY !== 1'b1) begin n_fail++; $display("FAIL pre_busy: got %0h want 1", if4.BUSY); end
    n_tests++; if (if4.PHASE !== 3'd6) begin n_fail++; $display("FAIL pre0_phase: got %0d want 6", if4.PHASE); end
    n_tests++; if (if4.CTRL_IN_BUF !== 3'd0) begin n_fail++; $display("FAIL pre0_buf: got %0d want 0", if4.CTRL_IN_BUF); end
    n_tests++; if (if4.CTRL_B !== 12'hFFF) begin n_fail++; $display("FAIL pre0_ctrl: got %0h want fff", if4.CTRL_B); end
    tick();
    n_tests++; if (if4.PHASE !== 3'd7) begin n_fail++; $display("FAIL pre1_phase: got %0d want 7", if4.PHASE); end
    n_tests++; if (if4.CTRL_IN_BUF !== 3'd1) begin n_fail++; $display("FAIL pre1_buf: got %0d want 1", if4.CTRL_IN_BUF); end
    n_tests++; if (if4.CARRY_IN !== 1'b0) begin n_fail++; $display("FAIL pre1_carry: got %0h want 0", if4.CARRY_IN); end
    tick();
    n_tests++; if (if4.PHASE !== 3'd0) begin n_fail++; $display("FAIL run0_phase: got %0d want 0", if4.PHASE); end
    n_tests++; if (if4.CTRL_B !== 12'hFF8) begin n_fail++; $display("FAIL run0_ctrl: got %0h want ff8", if4.CTRL_B); end
    n_tests++; if (if4.CTRL_IN_BUF !== 3'd2) begin n_fail++; $display("FAIL run0_buf: got %0d want 2", if4.CTRL_IN_BUF); end
    n_tests++; if (if4.CARRY_IN !== 1'b0) begin n_fail++; $display("FAIL run0_carry: got %0h want 0", if4.CARRY_IN); end
    tick(); tick(); tick();
    n_tests++; if (if4.CTRL_B !== 12'h053) begin n_fail++; $display("FAIL run3_ctrl: got %0h want 053", if4.CTRL_B); end
    n_tests++; if (if4.CARRY_IN !== 1'b0) begin n_fail++; $display("FAIL run3_carry: got %0h want 0", if4.CARRY_IN); end
    n_tests++; if (if4.DONE !== 1'b0) begin n_fail++; $display("FAIL run3_done: got %0h want 0", if4.DONE); end
    tick();
    n_tests++; if (if4.CTRL_B !== 12'h29F) begin n_fail++; $display("FAIL run4_ctrl: got %0h want 29f", if4.CTRL_B); end
    n_tests++; if (if4.CARRY_IN !== 1'b1) begin n_fail++; $display("FAIL run4_carry: got %0h want 1", if4.CARRY_IN); end
    tick(); tick(); tick();
    n_tests++; if (if4.PHASE !== 3'd7) begin n_fail++; $display("FAIL run7_phase: got %0d want 7", if4.PHASE); end
    n_tests++; if (if4.CTRL_B !== 12'hFFF) begin n_fail++; $display("FAIL run7_ctrl: got %0h want fff", if4.CTRL_B); end
    n_tests++; if (if4.DONE !== 1'b1) begin n_fail++; $display("FAIL run7_done: got %0h want 1", if4.DONE); end
    tick();
    n_tests++; if (if4.BUSY !== 1'b0) begin n_fail++; $display("FAIL end_busy: got %0h want 0", if4.BUSY); end
    n_tests++; if (if4.DONE !== 1'b0) begin n_fail++; $display("FAIL end_done: got %0h want 0", if4.DONE); end
    n_tests++; if (if4.PHASE !== 3'd6) begin n_fail++; $display("FAIL end_phase: got %0d want 6", if4.PHASE); end
  endtask

  task automatic test_continuous;
    int cnt;
    if4.MODE  = 1'b1;
    if4.START = 1'b1;
    tick();
    if4.START = 1'b0;
    cnt = 0;
    while (!if4.DONE && cnt < 20) begin tick(); cnt++; end
    n_tests++; if (cnt !== 9) begin n_fail++; $display("FAIL cont_first_done: got %0d cycles want 9", cnt); end
    tick();
    n_tests++; if (if4.PHASE !== 3'd0) begin n_fail++; $display("FAIL cont_wrap_phase: got %0d want 0", if4.PHASE); end
    n_tests++; if (if4.BUSY !== 1'b1) begin n_fail++; $display("FAIL cont_wrap_busy: got %0h want 1", if4.BUSY); end
    n_tests++; if (if4.CTRL_IN_BUF !== 3'd2) begin n_fail++; $display("FAIL cont_wrap_buf: got %0d want 2", if4.CTRL_IN_BUF); end
    cnt = 1;
    while (!if4.DONE && cnt < 20) begin tick(); cnt++; end
    n_tests++; if (cnt !== 8) begin n_fail++; $display("FAIL cont_period: got %0d want 8", cnt); end
    tick();
    if4.MODE = 1'b0;
    cnt = 1;
    while (!if4.DONE && cnt < 20) begin tick(); cnt++; end
    n_tests++; if (cnt !== 8) begin n_fail++; $display("FAIL cont_period2: got %0d want 8", cnt); end
    tick();
    n_tests++; if (if4.BUSY !== 1'b0) begin n_fail++; $display("FAIL cont_stop_busy: got %0h want 0", if4.BUSY); end
    n_tests++; if (if4.PHASE !== 3'd6) begin n_fail++; $display("FAIL cont_stop_phase: got %0d want 6", if4.PHASE); end
  endtask

  task automatic test_abort;
    if4.MODE  = 1'b0;
    if4.START = 1'b1;
    tick();
    if4.START = 1'b0;
    repeat (5) tick();
    n_tests++; if (if4.PHASE !== 3'd3) begin n_fail++; $display("FAIL abort_setup_phase: got %0d want 3", if4.PHASE); end
    if4.ABORT = 1'b1;
    if4.START = 1'b1;
    tick();
    n_tests++; if (if4.BUSY !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %0h want 0", if4.BUSY); end
    n_tests++; if (if4.PHASE !== 3'd6) begin n_fail++; $display("FAIL abort_phase: got %0d want 6", if4.PHASE); end
    n_tests++; if (if4.CTRL_B !== 12'hFFF) begin n_fail++; $display("FAIL abort_ctrl: got %0h want fff", if4.CTRL_B); end
    n_tests++; if (if4.CTRL_IN_BUF !== 3'd0) begin n_fail++; $display("FAIL abort_buf: got %0d want 0", if4.CTRL_IN_BUF); end
    n_tests++; if (if4.DONE !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %0h want 0", if4.DONE); end
    if4.ABORT = 1'b0;
    if4.START = 1'b0;
    tick();
    n_tests++; if (if4.BUSY !== 1'b0) begin n_fail++; $display("FAIL abort_norestart: got %0h want 0", if4.BUSY); end
  endtask

  task automatic test_reset_mid_run;
    int cnt;
    if4.START = 1'b1;
    tick();
    if4.START = 1'b0;
    repeat (7) tick();
    n_tests++; if (if4.PHASE !== 3'd5) begin n_fail++; $display("FAIL rst_setup_phase: got %0d want 5", if4.PHASE); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++; if (if4.BUSY !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0h want 0", if4.BUSY); end
    n_tests++; if (if4.PHASE !== 3'd6) begin n_fail++; $display("FAIL rst_phase: got %0d want 6", if4.PHASE); end
    if4.START = 1'b1;
    tick();
    if4.START = 1'b0;
    cnt = 0;
    while (!if4.DONE && cnt < 20) begin tick(); cnt++; end
    n_tests++; if (cnt !== 9) begin n_fail++; $display("FAIL rst_rerun_len: got %0d want 9", cnt); end
    tick();
    n_tests++; if (if4.BUSY !== 1'b0) begin n_fail++; $display("FAIL rst_rerun_idle: got %0h want 0", if4.BUSY); end
  endtask

  task automatic test_nb8;
    logic [3:0] exp_lane7;
    if8.MODE  = 1'b0;
    if8.START = 1'b1;
    tick();
    if8.START = 1'b0;
    for (int p = 13; p < 16; p++) begin
      n_tests++; if (if8.PHASE !== 4'(p)) begin n_fail++; $display("FAIL nb8_pre_phase: got %0d want %0d", if8.PHASE, p); end
      n_tests++; if (if8.CTRL_B !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL nb8_pre_ctrl: got %0h want ffffffff", if8.CTRL_B); end
      tick();
    end
    for (int p = 0; p < 16; p++) begin
      exp_lane7 = (p >= 7 && p <= 14) ? 4'(p - 7) : 4'hF;
      n_tests++; if (if8.PHASE !== 4'(p)) begin n_fail++; $display("FAIL nb8_run_phase: got %0d want %0d", if8.PHASE, p); end
      n_tests++; if (if8.CTRL_B[31:28] !== exp_lane7) begin n_fail++; $display("FAIL nb8_lane7 p%0d: got %0d want %0d", p, if8.CTRL_B[31:28], exp_lane7); end
      n_tests++; if (if8.CARRY_IN !== (p >= 8)) begin n_fail++; $display("FAIL nb8_carry p%0d: got %0h", p, if8.CARRY_IN); end
      n_tests++; if (if8.CTRL_IN_BUF !== 4'((p + 3) % 16)) begin n_fail++; $display("FAIL nb8_buf p%0d: got %0d", p, if8.CTRL_IN_BUF); end
      n_tests++; if (if8.DONE !== (p == 15)) begin n_fail++; $display("FAIL nb8_done p%0d: got %0h", p, if8.DONE); end
      if (p == 15) begin
        n_tests++; if (if8.CTRL_B !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL nb8_end_ctrl: got %0h want ffffffff", if8.CTRL_B); end
      end
      tick();
    end
    n_tests++; if (if8.BUSY !== 1'b0) begin n_fail++; $display("FAIL nb8_idle: got %0h want 0", if8.BUSY); end
  endtask

`ifdef MUL_CTRL_SEQ_STALL_EN
  task automatic test_stall;
    if4.MODE  = 1'b0;
    if4.START = 1'b1;
    tick();
    if4.START = 1'b0;
    repeat (9) tick();
    n_tests++; if (if4.PHASE !== 3'd7) begin n_fail++; $display("FAIL stall_setup_phase: got %0d want 7", if4.PHASE); end
    if4.STALL = 1'b1;
    #1;
    n_tests++; if (if4.DONE !== 1'b0) begin n_fail++; $display("FAIL stall_done0: got %0h want 0", if4.DONE); end
    tick();
    n_tests++; if (if4.PHASE !== 3'd7) begin n_fail++; $display("FAIL stall_phase1: got %0d want 7", if4.PHASE); end
    n_tests++; if (if4.DONE !== 1'b0) begin n_fail++; $display("FAIL stall_done1: got %0h want 0", if4.DONE); end
    tick();
    n_tests++; if (if4.PHASE !== 3'd7) begin n_fail++; $display("FAIL stall_phase2: got %0d want 7", if4.PHASE); end
    if4.STALL = 1'b0;
    #1;
    n_tests++; if (if4.DONE !== 1'b1) begin n_fail++; $display("FAIL stall_release_done: got %0h want 1", if4.DONE); end
    tick();
    n_tests++; if (if4.BUSY !== 1'b0) begin n_fail++; $display("FAIL stall_idle: got %0h want 0", if4.BUSY); end
  endtask
`endif

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    if4.START = 1'b0; if4.MODE = 1'b0; if4.ABORT = 1'b0;
    if8.START = 1'b0; if8.MODE = 1'b0; if8.ABORT = 1'b0;
`ifdef MUL_CTRL_SEQ_STALL_EN
    if4.STALL = 1'b0;
    if8.STALL = 1'b0;
`endif
    test_reset();
    test_single_shot();
    test_continuous();
    test_abort();
    test_reset_mid_run();
    test_nb8();
`ifdef MUL_CTRL_SEQ_STALL_EN
    test_stall();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
